core_loader: RTL and testbench
==============================

// Module: core_loader
// PURPOSE
//  Upstream boot stage for Core. Receives a framed program as a byte stream over a valid/ready
//  handshake (typically from a UART receiver), writes it into the instruction-memory write port
//  and zero-fills unused words. After a verified checksum it raises core_start to release Core.
//  Frame: SYNC byte, LEN byte (1..DEPTH), LEN payload bytes, CSUM byte.
// PARAMETERS
//  DATA_W     8      instruction / stream byte width
//  ADDR_W     4      instruction-memory address width; DEPTH = 2**ADDR_W = 16
//  SYNC_BYTE  8'hA5  frame start marker
// PORTS
//  clk         in   1       system clock; single clock domain
//  rst_n       in   1       synchronous, active-low reset
//  in_valid    in   1       stream byte valid
//  in_data     in   DATA_W  stream byte
//  in_ready    out  1       loader accepts byte; transfer = in_valid & in_ready
//  im_we       out  1       instruction-memory write enable (one word per cycle)
//  im_addr     out  ADDR_W  write address
//  im_wdata    out  DATA_W  write data
//  core_start  out  1       level; high = Core runs; low = Core held
//  busy        out  1       high in LEN/LOAD/CHECK/FILL
//  err         out  1       sticky error flag
//  err_code    out  2       01 bad length, 10 checksum mismatch, 00 none
// BEHAVIOUR
//  Reset: clk edge with rst_n=0 -> state IDLE; im_we=0, im_addr=0, im_wdata=0, core_start=0,
//   busy=0, err=0, err_code=00, cnt=0, sum=0. Reset mid-load or mid-run aborts immediately.
//  All outputs are registered except in_ready, which is decoded from state.
//  in_ready=1 in IDLE, LEN, LOAD, CHECK, ERROR; 0 in FILL, RUN.
//  FSM (advances only on transfer unless noted):
//   IDLE : byte==SYNC_BYTE -> LEN; any other byte is discarded.
//   LEN  : 1<=byte<=DEPTH -> len=byte, cnt=0, sum=0 -> LOAD;
//          otherwise -> ERROR with err_code=01. Compare as DATA_W-bit unsigned.
//   LOAD : each byte: cycle after the transfer im_we=1, im_addr=cnt, im_wdata=byte;
//          sum=sum+byte mod 2**DATA_W; cnt++. Transfer of byte number len -> CHECK.
//   CHECK: byte==sum -> FILL if len<DEPTH, else RUN directly.
//          Mismatch -> ERROR with err_code=10; memory contents are left as written.
//   FILL : no input; one write per cycle, im_we=1, im_addr=cnt, im_wdata=0, cnt++.
//          Write to address DEPTH-1 issued -> RUN on that edge.
//   RUN  : core_start=1 from the first cycle in RUN; held until reset. Input is ignored
//          (in_ready=0). A reload requires rst_n.
//   ERROR: err=1, core_start=0, bytes consumed and discarded; SYNC_BYTE -> LEN,
//          clearing err and err_code on that edge. This is the only non-reset error exit.
//  im_we is deasserted in every cycle that does not carry a LOAD or FILL write.
//  cnt is ADDR_W+1 bits so that len=DEPTH is representable without wrap.
//  SYNC_BYTE value inside LEN/LOAD/CHECK is ordinary data, not a resync.
//  in_valid low stalls any receiving state indefinitely; no timeout.
//  Latency: payload byte transfer -> im_we 1 cycle later.
//   CHECK transfer -> core_start 1 cycle later (len=DEPTH) or DEPTH-len+1 cycles later.
// STRUCTURE
//  Shared package core_pkg: DATA_W, ADDR_W, DEPTH, SYNC_BYTE.
//  Also in core_pkg: loader state encoding (IDLE, LEN, LOAD, CHECK, FILL, RUN, ERROR)
//   and err_code constants.
//  Single module; checksum accumulator is inline (no sub-module). Top level replaces
//   Core's external start with core_start and adds the write port to Im.
// TESTING
//  1 A5,03,11,22,33,66 back-to-back -> writes 0:11 1:22 2:33 then 3..15:00;
//    core_start rises 14 cycles after the CSUM transfer.
//  2 Full frame: LEN=16, 16 bytes, correct CSUM -> no FILL writes; core_start high
//    1 cycle after the CSUM transfer.
//  3 A5,00 and A5,11 -> err=1, err_code=01, no im_we; following A5,01,7F,7F -> err clears,
//    0:7F written, core_start=1.
//  4 A5,02,01,02,04 (bad CSUM) -> err_code=10, core_start stays 0, in_ready stays 1.
//  5 Noise 00,FF,12 before A5 -> discarded with no writes; in_valid gaps inside LOAD
//    -> same memory image as back-to-back.
//  6 rst_n=0 mid-LOAD and again in RUN -> next edge all outputs at reset values;
//    new frame loads normally.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the Core boot path: stream/memory geometry, the frame start
// marker, the loader state encoding and the loader error codes.
package core_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  localparam logic [DATA_W-1:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StLoad,
    StCheck,
    StFill,
    StRun,
    StError
  } ld_state_e;

  localparam logic [1:0] ErrNone = 2'b00;
  localparam logic [1:0] ErrLen  = 2'b01;
  localparam logic [1:0] ErrCsum = 2'b10;

endpackage

// File: rtl/core_loader.sv
// Boot loader for Core. Accepts a framed program (SYNC, LEN, LEN payload bytes, CSUM) over a
// valid/ready byte stream, writes the payload into instruction memory, zero-fills the rest
// and, once the checksum matches, holds core_start high until reset.
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   in_valid/in_data     incoming stream byte; in_ready accepts it (decoded from state)
//   im_we/im_addr/im_wdata  instruction-memory write port, one word per cycle
//   core_start           level, high releases Core
//   busy                 high while a frame is in flight (LEN/LOAD/CHECK/FILL)
//   err/err_code         sticky error flag and cause (01 bad length, 10 checksum)
module core_loader
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              core_start,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [DATA_W-1:0] DepthByte = DATA_W'(DEPTH);
  localparam logic [ADDR_W:0]   DepthCnt  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LastAddr  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CntOne    = (ADDR_W+1)'(1);

  ld_state_e         state;
  // One extra bit so that len = DEPTH is representable.
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   cnt;
  logic [DATA_W-1:0] sum;
  logic              xfer;

  always_comb begin
    in_ready = 1'b0;
    case (state)
      StIdle, StLen, StLoad, StCheck, StError: in_ready = 1'b1;
      default:                                 in_ready = 1'b0;
    endcase
  end

  assign xfer = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= StIdle;
      len        <= '0;
      cnt        <= '0;
      sum        <= '0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      core_start <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ErrNone;
    end else begin
      im_we <= 1'b0;
      case (state)
        StIdle: begin
          if (xfer && in_data == SYNC_BYTE) begin
            state <= StLen;
            busy  <= 1'b1;
          end
        end
        StLen: begin
          if (xfer) begin
            if (in_data != '0 && in_data <= DepthByte) begin
              len   <= in_data[ADDR_W:0];
              cnt   <= '0;
              sum   <= '0;
              state <= StLoad;
            end else begin
              state    <= StError;
              busy     <= 1'b0;
              err      <= 1'b1;
              err_code <= ErrLen;
            end
          end
        end
        StLoad: begin
          if (xfer) begin
            im_we    <= 1'b1;
            im_addr  <= cnt[ADDR_W-1:0];
            im_wdata <= in_data;
            sum      <= sum + in_data;
            cnt      <= cnt + CntOne;
            if (cnt + CntOne == len) begin
              state <= StCheck;
            end
          end
        end
        StCheck: begin
          if (xfer) begin
            if (in_data == sum) begin
              if (len == DepthCnt) begin
                state      <= StRun;
                busy       <= 1'b0;
                core_start <= 1'b1;
              end else begin
                state <= StFill;
              end
            end else begin
              // Memory keeps whatever was written; only a new frame overwrites it.
              state    <= StError;
              busy     <= 1'b0;
              err      <= 1'b1;
              err_code <= ErrCsum;
            end
          end
        end
        StFill: begin
          im_we    <= 1'b1;
          im_addr  <= cnt[ADDR_W-1:0];
          im_wdata <= '0;
          cnt      <= cnt + CntOne;
          if (cnt == LastAddr) begin
            state      <= StRun;
            busy       <= 1'b0;
            core_start <= 1'b1;
          end
        end
        StRun: begin
          // Terminal until reset.
        end
        StError: begin
          if (xfer && in_data == SYNC_BYTE) begin
            state    <= StLen;
            busy     <= 1'b1;
            err      <= 1'b0;
            err_code <= ErrNone;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_core_loader.sv
module tb_core_loader;
  import core_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_wdata;
  logic              core_start;
  logic              busy;
  logic              err;
  logic [1:0]        err_code;

  int vectors;
  int miscompares;
  int cyc;
  int t0;
  int lat;
  int wr_cnt;
  logic [7:0] mem_img [16];
  logic [7:0] exp_img [16];

  core_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .core_start (core_start),
    .busy       (busy),
    .err        (err),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory image as seen on the write port; cleared while reset is held.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem_img[i] = 8'hEE;
      wr_cnt = 0;
    end else if (im_we === 1'b1) begin
      mem_img[im_addr] = im_wdata;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".im_we"},      32'(im_we),      32'd0);
    check({tag, ".im_addr"},    32'(im_addr),    32'd0);
    check({tag, ".im_wdata"},   32'(im_wdata),   32'd0);
    check({tag, ".core_start"}, 32'(core_start), 32'd0);
    check({tag, ".busy"},       32'(busy),       32'd0);
    check({tag, ".err"},        32'(err),        32'd0);
    check({tag, ".err_code"},   32'(err_code),   32'd0);
    check({tag, ".in_ready"},   32'(in_ready),   32'd1);
  endtask

  task automatic do_reset(input bit chk, input string tag);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    if (chk) check_reset_vals(tag);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Presents one byte and holds it for exactly one accepting edge.
  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_start(output int l);
    l = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (core_start === 1'b1) begin
        l = cyc - t0 + 1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_image(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s.mem[%0d]", tag, i), 32'(mem_img[i]), 32'(exp_img[i]));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    t0          = 0;
    in_valid    = 1'b0;
    in_data     = '0;
    rst_n       = 1'b0;
    @(posedge clk);
    do_reset(1'b1, "reset");

    // 1: short frame with zero fill
    send(8'hA5);
    check("t1.busy_len", 32'(busy), 32'd1);
    send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    send(8'h66);
    t0 = cyc;
    idle(0);
    wait_start(lat);
    check("t1.latency", 32'(lat), 32'd14);
    for (int i = 0; i < 16; i++) exp_img[i] = 8'h00;
    exp_img[0] = 8'h11; exp_img[1] = 8'h22; exp_img[2] = 8'h33;
    check_image("t1");
    check("t1.wr_cnt", 32'(wr_cnt), 32'd16);
    check("t1.busy_run", 32'(busy), 32'd0);
    check("t1.in_ready_run", 32'(in_ready), 32'd0);

    // 2: full-length frame, no fill
    do_reset(1'b0, "");
    send(8'hA5); send(8'h10);
    for (int i = 1; i <= 16; i++) send(8'(i));
    send(8'h88);
    t0 = cyc;
    idle(0);
    wait_start(lat);
    check("t2.latency", 32'(lat), 32'd1);
    for (int i = 0; i < 16; i++) exp_img[i] = 8'(i + 1);
    check_image("t2");
    check("t2.wr_cnt", 32'(wr_cnt), 32'd16);
    send(8'hA5); send(8'h01); send(8'h02);
    idle(2);
    check("t2.run_ignores_input", 32'(wr_cnt), 32'd16);
    check("t2.core_start_held", 32'(core_start), 32'd1);

    // 3: bad lengths, recovery through SYNC in ERROR
    do_reset(1'b0, "");
    send(8'hA5); send(8'h00);
    idle(1);
    check("t3.err_len0", 32'(err), 32'd1);
    check("t3.code_len0", 32'(err_code), 32'd1);
    check("t3.busy_err", 32'(busy), 32'd0);
    send(8'hA5);
    check("t3.err_cleared", 32'(err), 32'd0);
    check("t3.code_cleared", 32'(err_code), 32'd0);
    send(8'h11);
    idle(1);
    check("t3.err_len17", 32'(err), 32'd1);
    check("t3.code_len17", 32'(err_code), 32'd1);
    check("t3.no_writes", 32'(wr_cnt), 32'd0);
    send(8'hA5); send(8'h01); send(8'h7F);
    send(8'h7F);
    t0 = cyc;
    idle(0);
    wait_start(lat);
    check("t3.latency", 32'(lat), 32'd16);
    check("t3.err_after", 32'(err), 32'd0);
    for (int i = 0; i < 16; i++) exp_img[i] = 8'h00;
    exp_img[0] = 8'h7F;
    check_image("t3");

    // 4: checksum mismatch
    do_reset(1'b0, "");
    send(8'hA5); send(8'h02); send(8'h01); send(8'h02); send(8'h04);
    idle(5);
    check("t4.err", 32'(err), 32'd1);
    check("t4.code", 32'(err_code), 32'd2);
    check("t4.core_start", 32'(core_start), 32'd0);
    check("t4.in_ready", 32'(in_ready), 32'd1);
    check("t4.wr_cnt", 32'(wr_cnt), 32'd2);
    check("t4.mem0", 32'(mem_img[0]), 32'h01);
    check("t4.mem1", 32'(mem_img[1]), 32'h02);

    // 5: leading noise, then gaps inside LOAD
    do_reset(1'b0, "");
    send(8'h00); send(8'hFF); send(8'h12);
    idle(2);
    check("t5.noise_writes", 32'(wr_cnt), 32'd0);
    check("t5.noise_busy", 32'(busy), 32'd0);
    send(8'hA5); send(8'h03); send(8'h11);
    idle(2);
    send(8'h22);
    idle(3);
    send(8'h33);
    send(8'h66);
    t0 = cyc;
    idle(0);
    wait_start(lat);
    check("t5.latency", 32'(lat), 32'd14);
    for (int i = 0; i < 16; i++) exp_img[i] = 8'h00;
    exp_img[0] = 8'h11; exp_img[1] = 8'h22; exp_img[2] = 8'h33;
    check_image("t5");

    // 6: reset mid-LOAD and in RUN, then a clean reload
    do_reset(1'b0, "");
    send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
    check("t6.we_midload", 32'(im_we), 32'd1);
    do_reset(1'b1, "t6.rst_load");
    send(8'hA5); send(8'h01); send(8'h55); send(8'h55);
    t0 = cyc;
    idle(0);
    wait_start(lat);
    check("t6.latency1", 32'(lat), 32'd16);
    do_reset(1'b1, "t6.rst_run");
    send(8'hA5); send(8'h02); send(8'h0A); send(8'h0B);
    send(8'h15);
    t0 = cyc;
    idle(0);
    wait_start(lat);
    check("t6.latency2", 32'(lat), 32'd15);
    for (int i = 0; i < 16; i++) exp_img[i] = 8'h00;
    exp_img[0] = 8'h0A; exp_img[1] = 8'h0B;
    check_image("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
